// File: rtl/frame_streamer.sv
// rtl/frame_streamer.sv - raster-order frame reader with hblank, hold and 2-stage read pipeline
// Optional zero-border mode: define FRAME_STREAMER_PAD_EN.
module frame_streamer #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int HBLANK       = 2,
  parameter int ADDR_WIDTH   = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   hold,
  output logic                   mem_rd,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   valid_out,
  output logic                   sol,
  output logic                   eof,
  output logic                   busy,
  output logic                   done
);

`ifdef FRAME_STREAMER_PAD_EN
  localparam int COLS = IMAGE_WIDTH + 2;
  localparam int ROWS = IMAGE_HEIGHT + 2;
`else
  localparam int COLS = IMAGE_WIDTH;
  localparam int ROWS = IMAGE_HEIGHT;
`endif
  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
  localparam logic [BW-1:0] B_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_BLANK, S_DRAIN} state_t;

  state_t                 state_q;
  logic [XW-1:0]          x_q;
  logic [YW-1:0]          y_q;
  logic [BW-1:0]          blk_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   tag_vld_q, tag_sol_q, tag_eof_q;
  logic [PIXEL_WIDTH-1:0] pixel_q;
  logic                   valid_q, sol_q, eof_q, busy_q, done_q;
  logic                   issue, interior;

  assign issue = (state_q == S_READ) && !hold;
`ifdef FRAME_STREAMER_PAD_EN
  logic tag_pad_q;
  assign interior = (x_q != '0) && (x_q != X_LAST) && (y_q != '0) && (y_q != Y_LAST);
`else
  assign interior = 1'b1;
`endif

  assign mem_rd    = issue && interior;
  assign mem_addr  = addr_q;
  assign pixel_out = pixel_q;
  assign valid_out = valid_q;
  assign sol       = sol_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      blk_q     <= '0;
      addr_q    <= '0;
      tag_vld_q <= 1'b0;
      tag_sol_q <= 1'b0;
      tag_eof_q <= 1'b0;
`ifdef FRAME_STREAMER_PAD_EN
      tag_pad_q <= 1'b0;
`endif
      pixel_q   <= '0;
      valid_q   <= 1'b0;
      sol_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      // Stage 1: tag follows the read into the RAM's one-cycle latency
      tag_vld_q <= issue;
      tag_sol_q <= issue && (x_q == '0);
      tag_eof_q <= issue && (x_q == X_LAST) && (y_q == Y_LAST);
      // Stage 2: output register
      valid_q   <= tag_vld_q;
      sol_q     <= tag_vld_q && tag_sol_q;
      eof_q     <= tag_vld_q && tag_eof_q;
`ifdef FRAME_STREAMER_PAD_EN
      tag_pad_q <= !interior;
      if (tag_vld_q) pixel_q <= tag_pad_q ? '0 : mem_rdata;
`else
      if (tag_vld_q) pixel_q <= mem_rdata;
`endif
      if (mem_rd) addr_q <= addr_q + ADDR_WIDTH'(1);

      case (state_q)
        S_IDLE: begin
          // done_q gate: a start coinciding with the done pulse is dropped
          if (start && !done_q) begin
            state_q <= S_READ;
            busy_q  <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
          end
        end
        S_READ: begin
          if (!hold) begin
            if (x_q == X_LAST) begin
              x_q <= '0;
              if (y_q == Y_LAST) begin
                state_q <= S_DRAIN;
              end else begin
                y_q   <= y_q + YW'(1);
                blk_q <= '0;
                if (HBLANK != 0) state_q <= S_BLANK;
              end
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        S_BLANK: begin
          if (!hold) begin
            if (blk_q == B_LAST) state_q <= S_READ;
            else                 blk_q   <= blk_q + BW'(1);
          end
        end
        S_DRAIN: begin
          if (!tag_vld_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// tb/tb_frame_streamer.sv - directed self-checking bench for frame_streamer
module tb_frame_streamer;

`ifdef FRAME_STREAMER_PAD_EN
  localparam int W = 4, H = 4, COLS = 6, ROWS = 6, OFFS = 1;
`else
  localparam int W = 8, H = 8, COLS = 8, ROWS = 8, OFFS = 0;
`endif
  localparam int NPX = COLS * ROWS;
  localparam int AW  = $clog2(W * H);

  logic clk = 1'b0;
  logic rst = 1'b1, hold = 1'b0, start_a = 1'b0, start_b = 1'b0, sel = 1'b0;

  logic          a_rd, b_rd, a_valid, b_valid, a_sol, b_sol, a_eof, b_eof;
  logic          a_busy, b_busy, a_done, b_done;
  logic [AW-1:0] a_addr, b_addr;
  logic [7:0]    a_rdata = '0, b_rdata = '0, a_pix, b_pix;

  logic          m_rd, m_valid, m_sol, m_eof, m_busy, m_done;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_pix;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  frame_streamer #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .hold(hold),
    .mem_rd(a_rd), .mem_addr(a_addr), .mem_rdata(a_rdata),
    .pixel_out(a_pix), .valid_out(a_valid), .sol(a_sol), .eof(a_eof),
    .busy(a_busy), .done(a_done));

  frame_streamer #(.PIXEL_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .HBLANK(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .hold(hold),
    .mem_rd(b_rd), .mem_addr(b_addr), .mem_rdata(b_rdata),
    .pixel_out(b_pix), .valid_out(b_valid), .sol(b_sol), .eof(b_eof),
    .busy(b_busy), .done(b_done));

  // Image RAMs: ram[i] = i + OFFS, one-cycle read latency
  always @(posedge clk) begin
    if (a_rd) a_rdata <= 8'(a_addr) + 8'(OFFS);
    if (b_rd) b_rdata <= 8'(b_addr) + 8'(OFFS);
  end

  assign m_rd    = sel ? b_rd    : a_rd;
  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_pix   = sel ? b_pix   : a_pix;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_sol   = sel ? b_sol   : a_sol;
  assign m_eof   = sel ? b_eof   : a_eof;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;

  function automatic logic [7:0] exp_pix(input int q);
    int r, c;
    r = q / COLS;
    c = q % COLS;
`ifdef FRAME_STREAMER_PAD_EN
    if (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1) return 8'd0;
    return 8'((r - 1) * W + (c - 1) + 1);
`else
    return 8'(r * COLS + c);
`endif
  endfunction

  // Runs one frame on the selected DUT, holding in cycles hf..ht (hf=0: none).
  task automatic run_frame(input bit use_b, input int hb, input int hf, input int ht,
                           input int exp_eof, input int exp_done);
    int q, rd_n, r, eof_c, done_c;
    q = 0; rd_n = 0; eof_c = -1; done_c = -1;
    sel = use_b;
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    for (int c = 1; c <= exp_done + 2; c++) begin
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      hold = (hf > 0) && (c >= hf) && (c <= ht);
      #1;
      if (m_rd) begin
        n_vec++;
        if (m_addr !== AW'(rd_n)) begin
          n_err++; $display("FAIL rd_addr cyc %0d got %0d exp %0d", c, m_addr, rd_n);
        end
        rd_n++;
      end
      if (m_valid) begin
        r = 1 + q + hb * (q / COLS);
        if (hf > 0 && r >= hf) r += ht - hf + 1;
        n_vec++;
        if (m_pix !== exp_pix(q) || c != r + 2 || m_sol !== (q % COLS == 0) || m_eof !== (q == NPX - 1)) begin
          n_err++;
          $display("FAIL pixel q=%0d got %0d/cyc %0d/sol %0b/eof %0b exp %0d/cyc %0d", q, m_pix, c, m_sol, m_eof, exp_pix(q), r + 2);
        end
        q++;
      end else if (m_sol || m_eof) begin
        n_vec++; n_err++; $display("FAIL tag_no_valid cyc %0d sol %0b eof %0b exp 0 0", c, m_sol, m_eof);
      end
      if (m_eof) eof_c = c;
      if (m_done && done_c < 0) done_c = c;
      if (c == exp_done - 1 || c == exp_done) begin
        n_vec++;
        if (m_busy !== (c == exp_done - 1)) begin
          n_err++; $display("FAIL busy cyc %0d got %0b exp %0b", c, m_busy, c == exp_done - 1);
        end
      end
    end
    hold = 1'b0;
    n_vec += 4;
    if (q != NPX)         begin n_err++; $display("FAIL pix_count got %0d exp %0d", q, NPX); end
    if (rd_n != W * H)    begin n_err++; $display("FAIL rd_count got %0d exp %0d", rd_n, W * H); end
    if (eof_c != exp_eof) begin n_err++; $display("FAIL eof_cycle got %0d exp %0d", eof_c, exp_eof); end
    if (done_c != exp_done) begin n_err++; $display("FAIL done_cycle got %0d exp %0d", done_c, exp_done); end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (a_busy && n < 300) begin @(negedge clk); n++; end
    n_vec++;
    if (a_busy) begin n_err++; $display("FAIL idle_timeout busy got 1 exp 0"); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec += 2;
    if ({a_rd, a_addr, a_pix, a_valid, a_sol, a_eof, a_busy, a_done} !== '0) begin
      n_err++; $display("FAIL reset_a got %0b exp 0", {a_rd, a_addr, a_pix, a_valid, a_sol, a_eof, a_busy, a_done});
    end
    if ({b_rd, b_addr, b_pix, b_valid, b_sol, b_eof, b_busy, b_done} !== '0) begin
      n_err++; $display("FAIL reset_b got %0b exp 0", {b_rd, b_addr, b_pix, b_valid, b_sol, b_eof, b_busy, b_done});
    end
    rst = 1'b0;
  endtask

  task automatic test_baseline();  run_frame(1'b0, 2, 0, -1, 80, 81); endtask
  task automatic test_hold();      run_frame(1'b0, 2, 5, 7, 83, 84);  endtask
  task automatic test_hblank0();   run_frame(1'b1, 0, 0, -1, 66, 67); endtask
  task automatic test_pad();       run_frame(1'b0, 2, 0, -1, 48, 49); endtask

  task automatic test_start_busy();
    sel = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 84; c++) begin
      @(negedge clk);
      start_a = (c == 10 || c == 81 || c == 82);
      #1;
      if (c == 80) begin n_vec++; if (a_eof !== 1'b1) begin n_err++; $display("FAIL sb_eof80 got %0b exp 1", a_eof); end end
      if (c == 81) begin n_vec++; if (a_done !== 1'b1) begin n_err++; $display("FAIL sb_done81 got %0b exp 1", a_done); end end
      if (c == 82) begin n_vec++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL sb_busy82 got %0b exp 0", a_busy); end end
      if (c == 83) begin
        n_vec++;
        if ({a_busy, a_rd, a_addr} !== {1'b1, 1'b1, AW'(0)}) begin
          n_err++; $display("FAIL sb_restart83 busy/rd/addr got %0b/%0b/%0d exp 1/1/0", a_busy, a_rd, a_addr);
        end
      end
      if (c == 84) begin n_vec++; if (a_addr !== AW'(1)) begin n_err++; $display("FAIL sb_addr84 got %0d exp 1", a_addr); end end
    end
    start_a = 1'b0;
    wait_idle();
  endtask

  task automatic test_midframe_reset();
    int bad;
    sel = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (c == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({a_rd, a_addr, a_pix, a_valid, a_sol, a_eof, a_busy, a_done} !== '0) begin
      n_err++; $display("FAIL midrst_outputs got %0b exp 0", {a_rd, a_addr, a_pix, a_valid, a_sol, a_eof, a_busy, a_done});
    end
    bad = 0;
    for (int c = 22; c <= 60; c++) begin
      @(negedge clk); #1;
      if (a_done || a_valid || a_busy) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL midrst_quiet got %0d active cycles exp 0", bad); end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    #1;
    n_vec++;
    if ({a_rd, a_addr} !== {1'b1, AW'(0)}) begin
      n_err++; $display("FAIL midrst_restart rd/addr got %0b/%0d exp 1/0", a_rd, a_addr);
    end
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({a_valid, a_sol, a_pix} !== {1'b1, 1'b1, 8'd0}) begin
      n_err++; $display("FAIL midrst_first_pix valid/sol/pix got %0b/%0b/%0d exp 1/1/0", a_valid, a_sol, a_pix);
    end
    wait_idle();
  endtask

  task automatic test_rst_start();
    @(negedge clk);
    rst = 1'b1; start_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    #1;
    n_vec++;
    if ({a_busy, a_rd} !== 2'b00) begin n_err++; $display("FAIL rst_start busy/rd got %0b/%0b exp 0/0", a_busy, a_rd); end
    @(negedge clk);
    #1;
    n_vec++;
    if (a_busy !== 1'b0) begin n_err++; $display("FAIL rst_start_late busy got %0b exp 0", a_busy); end
  endtask

  initial begin
    test_reset();
`ifdef FRAME_STREAMER_PAD_EN
    test_pad();
    test_rst_start();
`else
    test_baseline();
    test_hold();
    test_hblank0();
    test_start_busy();
    test_midframe_reset();
    test_rst_start();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
